// File: rtl/pcma_iq_source.sv
// pcma_iq_source
//
// Transmit-side companion to the PCMA lock detector. Bit groups are buffered in a 2-entry FIFO
// and mapped onto an FM4 (QPSK) or FM8 (8PSK) constellation of radius amp_i. One symbol is
// emitted per rate-counter strobe as two's-complement I/Q samples with a one-cycle valid pulse.
//
// Optional feature macro: PCMA_IQ_SRC_PRBS_EN
//   Adds prbs_sel_i. When it is high, symbol bits come from an internal PRBS-15
//   (x^15 + x^14 + 1, seed all ones) that advances 3 bits per strobe. The FIFO is not popped
//   in that mode and underflow_o never sets.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   mode_i       3'b001 selects fm4, any other value selects fm8 (sampled per strobe)
//   enable_i     symbol generation enable (level)
//   rate_i       symbol period minus one, in clk cycles
//   amp_i        unsigned constellation radius A (sampled per strobe)
//   bits_i       symbol bits, fm4 uses [1:0]
//   bits_val_i   bits_i valid
//   prbs_sel_i   (PCMA_IQ_SRC_PRBS_EN only) use internal PRBS as the bit source
//   bits_rdy_o   FIFO can accept a group (registered)
//   I_data_o     I sample, held between strobes
//   Q_data_o     Q sample, held between strobes
//   data_val_o   one-cycle pulse per emitted symbol
//   underflow_o  sticky: a strobe found the FIFO empty; cleared while enable_i is low

module pcma_iq_source #(
    parameter int unsigned DATA_WIDTH_IQ = 10,
    parameter int unsigned RATE_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [2:0]               mode_i,
    input  logic                     enable_i,
    input  logic [RATE_WIDTH-1:0]    rate_i,
    input  logic [DATA_WIDTH_IQ-2:0] amp_i,
    input  logic [2:0]               bits_i,
    input  logic                     bits_val_i,
`ifdef PCMA_IQ_SRC_PRBS_EN
    input  logic                     prbs_sel_i,
`endif
    output logic                     bits_rdy_o,
    output logic [DATA_WIDTH_IQ-1:0] I_data_o,
    output logic [DATA_WIDTH_IQ-1:0] Q_data_o,
    output logic                     data_val_o,
    output logic                     underflow_o
);

    localparam int unsigned W = DATA_WIDTH_IQ;

    // ------------------------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------------------------
    logic [2:0]            fifo_q [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  rdy_q, rdy_d;
    logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]          i_q, i_d;
    logic [W-1:0]          q_q, q_d;
    logic                  val_q, val_d;
    logic                  uf_q, uf_d;

    // ------------------------------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------------------------------
    logic       strobe;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic       uf_event;
    logic       use_prbs;
    logic [2:0] sym_bits;

    assign strobe     = enable_i && (cnt_q == '0);
    assign push       = bits_val_i && rdy_q;
    assign fifo_empty = (count_q == 2'd0);

`ifdef PCMA_IQ_SRC_PRBS_EN
    logic [14:0] prbs_q, prbs_d;

    // Fibonacci form: feedback from taps 15 and 14, shifted in at the LSB.
    function automatic logic [14:0] prbs_step3(input logic [14:0] s);
        logic [14:0] t;
        t = s;
        for (int n = 0; n < 3; n++) begin
            t = {t[13:0], t[14] ^ t[13]};
        end
        return t;
    endfunction

    assign use_prbs = prbs_sel_i;
    assign prbs_d   = (strobe && use_prbs) ? prbs_step3(prbs_q) : prbs_q;
    assign sym_bits = use_prbs ? prbs_q[2:0] : fifo_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prbs_q <= '1;
        end else begin
            prbs_q <= prbs_d;
        end
    end
`else
    assign use_prbs = 1'b0;
    assign sym_bits = fifo_q[rd_ptr_q];
`endif

    // A push into an empty FIFO in a strobe cycle is not bypassed: the strobe underflows and
    // the new entry waits for the next strobe.
    assign pop      = strobe && !use_prbs && !fifo_empty;
    assign uf_event = strobe && !use_prbs && fifo_empty;

    // ------------------------------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        rdy_d = (count_d < 2'd2);
    end

    // ------------------------------------------------------------------------------------------
    // Rate counter: strobe when zero and reload, otherwise count down
    // ------------------------------------------------------------------------------------------
    always_comb begin
        cnt_d = '0;
        if (enable_i) begin
            if (cnt_q == '0) begin
                cnt_d = rate_i;
            end else begin
                cnt_d = cnt_q - RATE_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------------------------------
    // Constellation mapping
    // ------------------------------------------------------------------------------------------
    logic [W+7:0] diag_prod;
    logic [W-1:0] amp_pos, amp_neg;
    logic [W-1:0] diag_pos, diag_neg;
    logic         is_fm4;
    logic [2:0]   k_idx;
    logic [W-1:0] map_i, map_q;

    // c = round(A / sqrt(2)) with 181/256 ~= 0.7070; c <= A so it fits in W bits unsigned.
    assign diag_prod = ((W+8)'(amp_i) * (W+8)'(181)) + (W+8)'(128);
    assign diag_pos  = diag_prod[W+7:8];
    assign diag_neg  = W'(0) - diag_pos;
    assign amp_pos   = W'(amp_i);
    assign amp_neg   = W'(0) - amp_pos;
    assign is_fm4    = (mode_i == 3'b001);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    assign k_idx = {sym_bits[2],
                    sym_bits[2] ^ sym_bits[1],
                    sym_bits[2] ^ sym_bits[1] ^ sym_bits[0]};

    always_comb begin
        map_i = '0;
        map_q = '0;
        if (is_fm4) begin
            // Gray-coded quadrants: bit 0 flips the I sign, bit 1 flips the Q sign.
            map_i = sym_bits[0] ? diag_neg : diag_pos;
            map_q = sym_bits[1] ? diag_neg : diag_pos;
        end else begin
            unique case (k_idx)
                3'd0: begin map_i = amp_pos;  map_q = '0;       end
                3'd1: begin map_i = diag_pos; map_q = diag_pos; end
                3'd2: begin map_i = '0;       map_q = amp_pos;  end
                3'd3: begin map_i = diag_neg; map_q = diag_pos; end
                3'd4: begin map_i = amp_neg;  map_q = '0;       end
                3'd5: begin map_i = diag_neg; map_q = diag_neg; end
                3'd6: begin map_i = '0;       map_q = amp_neg;  end
                3'd7: begin map_i = diag_pos; map_q = diag_neg; end
                default: begin map_i = '0;    map_q = '0;       end
            endcase
        end
    end

    // ------------------------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------------------------
    always_comb begin
        i_d   = i_q;
        q_d   = q_q;
        val_d = strobe;
        uf_d  = uf_q;
        if (strobe) begin
            if (uf_event) begin
                i_d = '0;
                q_d = '0;
            end else begin
                i_d = map_i;
                q_d = map_q;
            end
        end
        if (!enable_i) begin
            uf_d = 1'b0;
        end else if (uf_event) begin
            uf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= '0;
            rdy_q     <= 1'b1;
            cnt_q     <= '0;
            i_q       <= '0;
            q_q       <= '0;
            val_q     <= 1'b0;
            uf_q      <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= bits_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
            cnt_q    <= cnt_d;
            i_q      <= i_d;
            q_q      <= q_d;
            val_q    <= val_d;
            uf_q     <= uf_d;
        end
    end

    assign bits_rdy_o  = rdy_q;
    assign I_data_o    = i_q;
    assign Q_data_o    = q_q;
    assign data_val_o  = val_q;
    assign underflow_o = uf_q;

endmodule

// File: tb/tb_pcma_iq_source.sv
// Self-checking bench for pcma_iq_source: directed constellation/timing/reset checks plus a
// randomized run compared cycle by cycle against a queue-based reference model.

module tb_pcma_iq_source;

    localparam int W  = 10;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    mode_i = 3'b010;
    logic          enable_i = 1'b0;
    logic [RW-1:0] rate_i = '0;
    logic [W-2:0]  amp_i = '0;
    logic [2:0]    bits_i = '0;
    logic          bits_val_i = 1'b0;
    logic          bits_rdy_o;
    logic [W-1:0]  I_data_o, Q_data_o;
    logic          data_val_o, underflow_o;

    pcma_iq_source #(.DATA_WIDTH_IQ(W), .RATE_WIDTH(RW)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode_i      (mode_i),
        .enable_i    (enable_i),
        .rate_i      (rate_i),
        .amp_i       (amp_i),
        .bits_i      (bits_i),
        .bits_val_i  (bits_val_i),
`ifdef PCMA_IQ_SRC_PRBS_EN
        .prbs_sel_i  (1'b0),
`endif
        .bits_rdy_o  (bits_rdy_o),
        .I_data_o    (I_data_o),
        .Q_data_o    (Q_data_o),
        .data_val_o  (data_val_o),
        .underflow_o (underflow_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;
    bit feed_on = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] to_w(input int v);
        logic [W-1:0] t;
        t = v[W-1:0];
        return 32'(t);
    endfunction

    // Reference constellation straight from the point tables.
    function automatic void model_point(input logic [2:0] mode, input int a, input int b,
                                        output int pi, output int pq);
        int c, k;
        c = (a * 181 + 128) / 256;
        if (mode == 3'b001) begin
            case (b & 3)
                0: begin pi =  c; pq =  c; end
                1: begin pi = -c; pq =  c; end
                3: begin pi = -c; pq = -c; end
                default: begin pi = c; pq = -c; end
            endcase
        end else begin
            k = b ^ (b >> 1) ^ (b >> 2);
            case (k)
                0: begin pi =  a; pq =  0; end
                1: begin pi =  c; pq =  c; end
                2: begin pi =  0; pq =  a; end
                3: begin pi = -c; pq =  c; end
                4: begin pi = -a; pq =  0; end
                5: begin pi = -c; pq = -c; end
                6: begin pi =  0; pq = -a; end
                default: begin pi = c; pq = -c; end
            endcase
        end
    endfunction

    // Reference model: FIFO as a queue, period counter as a plain integer.
    int m_fifo[$];
    int m_cnt = 0, m_i = 0, m_q = 0;
    bit m_val = 0, m_uf = 0, m_rdy = 1;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_fifo.delete();
            m_cnt = 0; m_i = 0; m_q = 0; m_val = 0; m_uf = 0; m_rdy = 1;
        end else begin
            bit push, strobe;
            push   = bits_val_i && m_rdy;
            strobe = enable_i && (m_cnt == 0);
            m_val  = strobe;
            if (!enable_i) m_cnt = 0;
            else if (m_cnt == 0) m_cnt = int'(rate_i);
            else m_cnt = m_cnt - 1;
            if (strobe) begin
                if (m_fifo.size() == 0) begin
                    m_i = 0; m_q = 0; m_uf = 1;
                end else begin
                    model_point(mode_i, int'(amp_i), m_fifo.pop_front(), m_i, m_q);
                end
            end
            if (!enable_i) m_uf = 0;
            if (push) m_fifo.push_back(int'(bits_i));
            m_rdy = (m_fifo.size() < 2);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("I", 32'(I_data_o), to_w(m_i));
            chk("Q", 32'(Q_data_o), to_w(m_q));
            chk("val", 32'(data_val_o), 32'(m_val));
            chk("uf", 32'(underflow_o), 32'(m_uf));
            chk("rdy", 32'(bits_rdy_o), 32'(m_rdy));
        end
    end

    // Captured output symbols.
    logic [W-1:0] got_i[$], got_q[$];
    int           got_cyc[$];
    initial forever begin
        @(negedge clk);
        if (data_val_o) begin
            got_i.push_back(I_data_o);
            got_q.push_back(Q_data_o);
            got_cyc.push_back(cyc);
        end
    end

    // Feeder: presents queued bit groups, advancing only when the DUT is ready.
    int feed[$];
    initial forever begin
        @(negedge clk);
        if (feed_on) begin
            if (feed.size() > 0 && bits_rdy_o) begin
                bits_val_i = 1'b1;
                bits_i     = 3'(feed.pop_front());
            end else begin
                bits_val_i = 1'b0;
            end
        end
    end

    task automatic clear_got();
        got_i.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic chk_sym(input string tag, input int idx, input int ei, input int eq);
        if (got_i.size() > idx) begin
            chk({tag, "_I"}, 32'(got_i[idx]), to_w(ei));
            chk({tag, "_Q"}, 32'(got_q[idx]), to_w(eq));
        end else begin
            chk({tag, "_present"}, 32'(got_i.size()), 32'(idx + 1));
        end
    endtask

    int fm8_bits[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    int fm8_ei[8]   = '{256, 181, 0, -181, -256, -181, 0, 181};
    int fm8_eq[8]   = '{0, 181, 256, 181, 0, -181, -256, -181};
    int fm4_bits[4] = '{0, 5, 3, 6};  // bit 2 set on two of them: must be ignored
    int fm4_ei[4]   = '{181, -181, -181, 181};
    int fm4_eq[4]   = '{181, 181, -181, -181};

    initial begin
        int e_cyc;
        repeat (3) @(negedge clk);
        chk("rst_I", 32'(I_data_o), 32'd0);
        chk("rst_Q", 32'(Q_data_o), 32'd0);
        chk("rst_val", 32'(data_val_o), 32'd0);
        chk("rst_uf", 32'(underflow_o), 32'd0);
        chk("rst_rdy", 32'(bits_rdy_o), 32'd1);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // fm8 constellation at A = 256, one symbol per cycle.
        mode_i = 3'b010; amp_i = 9'd256; rate_i = '0;
        foreach (fm8_bits[j]) feed.push_back(fm8_bits[j]);
        repeat (4) @(negedge clk);
        clear_got();
        enable_i = 1'b1;
        repeat (12) @(negedge clk);
        chk("fm8_uf_after_drain", 32'(underflow_o), 32'd1);
        enable_i = 1'b0;
        for (int j = 0; j < 8; j++) chk_sym($sformatf("fm8_%0d", j), j, fm8_ei[j], fm8_eq[j]);
        @(negedge clk);
        chk("uf_clear_on_disable", 32'(underflow_o), 32'd0);

        // fm4 constellation.
        mode_i = 3'b001;
        foreach (fm4_bits[j]) feed.push_back(fm4_bits[j]);
        repeat (4) @(negedge clk);
        clear_got();
        enable_i = 1'b1;
        repeat (8) @(negedge clk);
        enable_i = 1'b0;
        for (int j = 0; j < 4; j++) chk_sym($sformatf("fm4_%0d", j), j, fm4_ei[j], fm4_eq[j]);

        // rate_i = 3 with the FIFO kept full.
        mode_i = 3'b100; rate_i = 16'd3;
        for (int j = 0; j < 20; j++) feed.push_back(int'($urandom_range(0, 7)));
        repeat (4) @(negedge clk);
        chk("rdy_low_when_full", 32'(bits_rdy_o), 32'd0);
        clear_got();
        e_cyc = cyc;
        enable_i = 1'b1;
        repeat (14) @(negedge clk);
        enable_i = 1'b0;
        if (got_cyc.size() >= 3) begin
            chk("first_pulse_latency", 32'(got_cyc[0] - e_cyc), 32'd1);
            chk("period_1", 32'(got_cyc[1] - got_cyc[0]), 32'd4);
            chk("period_2", 32'(got_cyc[2] - got_cyc[1]), 32'd4);
        end else begin
            chk("rate3_pulses", 32'(got_cyc.size()), 32'd3);
        end
        feed.delete();

        // Drain, then enable with an empty FIFO.
        rate_i = '0; enable_i = 1'b1;
        repeat (6) @(negedge clk);
        enable_i = 1'b0;
        @(negedge clk);
        clear_got();
        rate_i = 16'd2; enable_i = 1'b1;
        @(negedge clk);
        chk_sym("uf_zero", 0, 0, 0);
        chk("uf_set", 32'(underflow_o), 32'd1);
        repeat (8) @(negedge clk);
        chk("uf_sticky", 32'(underflow_o), 32'd1);
        enable_i = 1'b0;
        @(negedge clk);
        chk("uf_cleared", 32'(underflow_o), 32'd0);

        // Asynchronous reset mid-stream.
        mode_i = 3'b011; amp_i = 9'd300; rate_i = 16'd1;
        for (int j = 0; j < 6; j++) feed.push_back(int'($urandom_range(0, 7)));
        repeat (3) @(negedge clk);
        enable_i = 1'b1;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_I", 32'(I_data_o), 32'd0);
        chk("arst_Q", 32'(Q_data_o), 32'd0);
        chk("arst_val", 32'(data_val_o), 32'd0);
        chk("arst_uf", 32'(underflow_o), 32'd0);
        chk("arst_rdy", 32'(bits_rdy_o), 32'd1);
        feed.delete();
        enable_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        clear_got();
        repeat (5) @(negedge clk);
        chk("no_val_until_enable", 32'(got_i.size()), 32'd0);

        // Randomized run against the model.
        feed_on = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (t % 50 == 0) begin
                mode_i = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom_range(0, 7));
                amp_i  = 9'($urandom_range(0, 511));
                rate_i = 16'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 39) == 0) enable_i = ~enable_i;
            bits_val_i = ($urandom_range(0, 9) < 6);
            bits_i     = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        bits_val_i = 1'b0;
        enable_i   = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcma_iq_source.md
# pcma_iq_source

Transmit-side companion to the PCMA lock detector. Maps incoming bit groups onto an FM4 (QPSK) or FM8 (8PSK) constellation. Emits two's-complement I/Q samples with a data-valid strobe at a programmable symbol rate, on the same I/Q/valid interface the detector consumes. Used as the modulator front end and as the closed-loop stimulus source for detector bring-up.

## Interface
- DATA_WIDTH_IQ, 10, width of I/Q outputs, two's complement
- RATE_WIDTH, 16, width of symbol-period register
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- mode_i  in  3  001 = fm4, any other value = fm8
- enable_i  in  1  symbol generation enable, level
- rate_i  in  RATE_WIDTH  symbol period minus one, in clk cycles
- amp_i  in  DATA_WIDTH_IQ-1  unsigned constellation radius A
- bits_i  in  3  symbol bits; fm4 uses [1:0], [2] ignored
- bits_val_i  in  1  bits_i valid
- bits_rdy_o  out  1  bit FIFO can accept
- I_data_o  out  DATA_WIDTH_IQ  I sample
- Q_data_o  out  DATA_WIDTH_IQ  Q sample
- data_val_o  out  1  one-cycle pulse per emitted symbol
- underflow_o  out  1  sticky, a symbol strobe found the FIFO empty

## Operation
- Reset values:
  - I_data_o = Q_data_o = 0; data_val_o = 0; underflow_o = 0.
  - bits_rdy_o = 1; rate counter = 0; FIFO empty.
- Bit FIFO: 2 entries.
  - bits_rdy_o = (count < 2), registered.
  - Push on bits_val_i && bits_rdy_o.
  - Pop on symbol strobe when not empty.
  - Push and pop in the same cycle are both performed.
- Rate counter, while enable_i = 1:
  - cnt == 0: assert strobe and load rate_i.
  - Otherwise: decrement.
  - Result: first strobe in the first enabled cycle, then every rate_i+1 cycles. rate_i = 0 gives a strobe every cycle.
- enable_i = 0: cnt forced to 0, no strobes, underflow_o cleared. FIFO contents are kept.
- Per strobe, mode_i and amp_i are sampled. Diagonal value c = (A*181 + 128) >> 8, unsigned, c ≤ A.
- fm8 mapping: index k = gray-to-binary(bits[2:0]). Points by k:
  - k0 (A,0); k1 (c,c); k2 (0,A); k3 (-c,c)
  - k4 (-A,0); k5 (-c,-c); k6 (0,-A); k7 (c,-c)
- fm4 mapping (Gray):
  - 00 → (c,c); 01 → (-c,c); 11 → (-c,-c); 10 → (c,-c)
- Negation is two's complement at DATA_WIDTH_IQ bits. amp_i width guarantees no overflow.
- Underflow (strobe with FIFO empty):
  - Emit (0,0) with data_val_o = 1 and set underflow_o.
  - A push in the same cycle is not bypassed; it is stored for the next strobe.
- FIFO entries are interpreted with mode_i at pop time. Mode changes take effect on the next strobe.

## Timing
- Latency: strobe in cycle n → I/Q and data_val_o valid in cycle n+1. data_val_o is high for exactly one cycle.
- I_data_o/Q_data_o hold their last value between strobes.
- bits_rdy_o updates in the cycle after the push/pop that changes the count.
- Asynchronous reset mid-symbol clears everything immediately. The first strobe after release follows the rate counter rule.
- Changing rate_i mid-period takes effect at the next reload.

## Configuration
- PCMA_IQ_SRC_PRBS_EN defined:
  - Adds input prbs_sel_i (1 bit).
  - When prbs_sel_i = 1, symbol bits come from an internal PRBS-15 (x^15+x^14+1, seed all ones). It advances 3 bits per strobe; fm4 uses the two LSBs.
  - In that mode the FIFO is not popped, bits_rdy_o reflects FIFO state, and underflow_o never sets.
- Macro undefined: no prbs_sel_i port; behaviour is identical to prbs_sel_i = 0.

## Test plan
- Reset, then amp_i=256, mode_i=010, rate_i=0. Push fm8 bits 000,001,011,010,110,111,101,100 → eight valid pulses:
  - (256,0) (181,181) (0,256) (-181,181)
  - (-256,0) (-181,-181) (0,-256) (181,-181), i.e. -181 = 0x34B
- mode_i=001, amp_i=256, push 00,01,11,10 → (181,181) (-181,181) (-181,-181) (181,-181).
- rate_i=3, FIFO kept full → data_val_o period exactly 4 cycles, first pulse 1 cycle after enable_i rises, bits_rdy_o deasserts at 2 entries.
- Enable with empty FIFO → (0,0) with data_val_o=1 and underflow_o=1. underflow_o stays high until enable_i=0.
- Assert reset_n low asynchronously mid-stream → all outputs 0 and bits_rdy_o=1 without waiting for a clock edge. After release, no data_val_o until enable_i=1.
- (PRBS_EN) prbs_sel_i=1, fm8 → first symbol index from bits 111 of the all-ones seed → (-181,-181) at amp 256; bits_rdy_o unaffected.
